axi_txn_tracking_monitor: RTL and testbench
===========================================

Name: axi_txn_tracking_monitor

Overview:
- Passive, parametrised AXI monitor. It snoops all five channels of one AXI link and tracks outstanding transactions per ID, for writes and reads separately.
- Provides a runtime-configurable progress watchdog for the W, B and R channels, sticky protocol-error flags, peak-occupancy statistics and one interrupt line.
- Sits beside a NoC master or slave interface and never drives handshake signals. It generalises the fixed five-channel snoop/timeout monitor to per-ID accounting and a runtime threshold.

Parameters:
- BW_AXI_TID, 4, AXI ID width; tracks 2^BW_AXI_TID IDs per direction.
- BW_OUTSTANDING, 4, width of each per-ID counter and of the peak registers.
- BW_TOTAL, 8, width of the total-outstanding outputs.
- BW_TIMER, 16, watchdog counter width.
- DEFAULT_TIMEOUT, 500, threshold loaded at reset (0 = watchdog disabled).

Ports:
- clk  input  1  clock
- rstnn  input  1  asynchronous active-low reset
- enable  input  1  when 0 the snoop registers, counters and timers hold
- clear  input  1  synchronous pulse; clears sticky flags and peaks
- cfg_timeout_we  input  1  load cfg_timeout
- cfg_timeout  input  BW_TIMER  new threshold; 0 disables all watchdogs
- awid/awlen/awvalid/awready  input  BW_AXI_TID/8/1/1  AW snoop
- wlast/wvalid/wready  input  1/1/1  W snoop
- bid/bvalid/bready  input  BW_AXI_TID/1/1  B snoop
- arid/arvalid/arready  input  BW_AXI_TID/1/1  AR snoop
- rid/rlast/rvalid/rready  input  BW_AXI_TID/1/1/1  R snoop
- wr_total  output  BW_TOTAL  sum of per-ID write counts
- rd_total  output  BW_TOTAL  sum of per-ID read counts
- wr_peak  output  BW_OUTSTANDING  max per-ID write count since clear
- rd_peak  output  BW_OUTSTANDING  max per-ID read count since clear
- timeout_flags  output  3  sticky {R,B,W}
- error_flags  output  4  sticky {UNEXP_R, UNEXP_B, RD_OVF, WR_OVF}
- irq  output  1  OR of timeout_flags and error_flags, registered

Behaviour:
- Reset: all outputs 0; snoop regs, counters and timers 0; threshold = DEFAULT_TIMEOUT.
- Stage 1: all inputs are registered when enable=1. A handshake (valid&ready) is evaluated on the registered copies.
- Stage 2: counters and flags update from stage-1 values.
- Latency: a port handshake in cycle N is visible on outputs in cycle N+2. irq is visible in N+3.
- AW handshake: wcnt[awid]++. B handshake: wcnt[bid]--.
- AR handshake: rcnt[arid]++. R handshake with rlast=1: rcnt[rid]--. Non-last R beats do not change counts.
- Same ID incremented and decremented in one cycle: net unchanged, no error.
- Increment at all-ones: counter saturates and sets WR_OVF or RD_OVF respectively.
- B with wcnt[bid]==0 (and no same-ID AW that cycle): count unchanged, set UNEXP_B. Same rule for R-last against rcnt, setting UNEXP_R.
- wburst_pend: signed counter, width BW_TOTAL+1. +1 per AW handshake, -1 per W handshake with wlast. May go negative, since W may precede AW.
- W watchdog:
  - Runs while wburst_pend>0 and no W handshake occurs that cycle.
  - Resets to 0 on any W handshake or when wburst_pend<=0.
- B watchdog: runs while wr_total>0 and no B handshake; resets on B handshake or when wr_total==0.
- R watchdog: runs while rd_total>0 and no R handshake; resets on R handshake or when rd_total==0.
- Timers saturate at the threshold. Reaching the threshold sets the matching sticky timeout flag.
- Threshold 0: timers are held at 0 and no timeout flag is ever set.
- cfg_timeout_we: loads the new threshold and zeroes all timers in the same cycle.
- Peaks update to max(peak, any per-ID count after update) every enabled cycle.
- clear with a coinciding set event: the set wins. Peaks reload from the current maximum, not 0.
- clear and cfg_timeout_we act even when enable=0. Counters and timers hold.
- Reset mid-transaction: all state is lost immediately and asynchronously; no recovery is attempted.

Test Plan:
- AW id=3, then AR id=3 twice, then R id=3 rlast=1 -> wr_total=1, rd_total=2→1, wr_peak=1, rd_peak=2; each change appears exactly 2 cycles after its handshake; error_flags=0.
- 16 AWs on id=5 with BW_OUTSTANDING=4 and no B -> wcnt saturates at 15, WR_OVF=1, irq=1 one cycle later; clear -> error_flags=0, wr_peak=15 retained.
- B id=2 with no prior AW -> UNEXP_B=1, wr_total stays 0. Same cycle as AW id=2 plus B id=2 -> no error, count 0.
- cfg_timeout=10, one AR outstanding, no R -> timeout_flags[2]=1 after 10 idle cycles. An R beat at cycle 9 resets the timer and no flag is set.
- W burst before its AW -> wburst_pend=-1 and no W timeout. After the AW, wburst_pend=0.
- enable=0 during a pending read with threshold 5 for 20 cycles -> timer and counts frozen, no timeout. Assert rstnn low mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/axi_txn_tracking_monitor.sv
// Passive AXI snoop monitor: per-ID outstanding accounting, progress watchdogs,
// sticky protocol-error flags, peak statistics and a single interrupt.

module axi_txn_id_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rstnn_i,
  input  logic         en_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_nxt_o,
  output logic         ovf_o,
  output logic         unexp_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // inc and dec together on one ID cancel out, including at the rails
  always_comb begin
    cnt_d   = cnt_q;
    ovf_o   = 1'b0;
    unexp_o = 1'b0;
    if (en_i && (inc_i != dec_i)) begin
      if (inc_i) begin
        if (&cnt_q) ovf_o = 1'b1;
        else        cnt_d = cnt_q + W'(1);
      end else begin
        if (cnt_q == '0) unexp_o = 1'b1;
        else             cnt_d   = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstnn_i)
    if (!rstnn_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
endmodule

module axi_txn_wdog #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rstnn_i,
  input  logic         en_i,
  input  logic         ld_i,
  input  logic [W-1:0] thr_i,
  input  logic         busy_i,
  input  logic         hs_i,
  output logic         hit_o
);
  logic [W-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    hit_o = 1'b0;
    if (ld_i) tmr_d = '0;
    else if (en_i) begin
      if (thr_i == '0 || hs_i || !busy_i) tmr_d = '0;
      else begin
        tmr_d = (tmr_q >= thr_i) ? thr_i : tmr_q + W'(1);
        hit_o = (tmr_d == thr_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstnn_i)
    if (!rstnn_i) tmr_q <= '0;
    else          tmr_q <= tmr_d;
endmodule

module axi_txn_tracking_monitor #(
  parameter int BW_AXI_TID      = 4,
  parameter int BW_OUTSTANDING  = 4,
  parameter int BW_TOTAL        = 8,
  parameter int BW_TIMER        = 16,
  parameter int DEFAULT_TIMEOUT = 500
) (
  input  logic                      clk,
  input  logic                      rstnn,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      cfg_timeout_we,
  input  logic [BW_TIMER-1:0]       cfg_timeout,
  input  logic [BW_AXI_TID-1:0]     awid,
  input  logic [7:0]                awlen,
  input  logic                      awvalid,
  input  logic                      awready,
  input  logic                      wlast,
  input  logic                      wvalid,
  input  logic                      wready,
  input  logic [BW_AXI_TID-1:0]     bid,
  input  logic                      bvalid,
  input  logic                      bready,
  input  logic [BW_AXI_TID-1:0]     arid,
  input  logic                      arvalid,
  input  logic                      arready,
  input  logic [BW_AXI_TID-1:0]     rid,
  input  logic                      rlast,
  input  logic                      rvalid,
  input  logic                      rready,
  output logic [BW_TOTAL-1:0]       wr_total,
  output logic [BW_TOTAL-1:0]       rd_total,
  output logic [BW_OUTSTANDING-1:0] wr_peak,
  output logic [BW_OUTSTANDING-1:0] rd_peak,
  output logic [2:0]                timeout_flags,
  output logic [3:0]                error_flags,
  output logic                      irq
);
  localparam int NUM_ID = 1 << BW_AXI_TID;
  localparam int PW     = BW_TOTAL + 1;

  typedef struct packed {
    logic [BW_AXI_TID-1:0] awid;  logic awvalid, awready;
    logic                  wlast, wvalid, wready;
    logic [BW_AXI_TID-1:0] bid;   logic bvalid, bready;
    logic [BW_AXI_TID-1:0] arid;  logic arvalid, arready;
    logic [BW_AXI_TID-1:0] rid;   logic rlast, rvalid, rready;
  } snoop_t;

  snoop_t snp_q, snp_d;
  assign snp_d = {awid, awvalid, awready, wlast, wvalid, wready, bid, bvalid, bready,
                  arid, arvalid, arready, rid, rlast, rvalid, rready};

  logic unused_awlen;
  assign unused_awlen = ^awlen;

  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn)      snp_q <= '0;
    else if (enable) snp_q <= snp_d;

  logic aw_hs, w_hs, wl_hs, b_hs, ar_hs, r_hs, rl_hs;
  assign aw_hs = snp_q.awvalid & snp_q.awready;
  assign w_hs  = snp_q.wvalid  & snp_q.wready;
  assign wl_hs = w_hs & snp_q.wlast;
  assign b_hs  = snp_q.bvalid  & snp_q.bready;
  assign ar_hs = snp_q.arvalid & snp_q.arready;
  assign r_hs  = snp_q.rvalid  & snp_q.rready;
  assign rl_hs = r_hs & snp_q.rlast;

  logic [NUM_ID-1:0][BW_OUTSTANDING-1:0] wcnt, rcnt, wcnt_nxt, rcnt_nxt;
  logic [NUM_ID-1:0] w_ovf, w_unexp, r_ovf, r_unexp;

  for (genvar i = 0; i < NUM_ID; i++) begin : g_id
    axi_txn_id_cnt #(.W(BW_OUTSTANDING)) u_wcnt (
      .clk_i(clk), .rstnn_i(rstnn), .en_i(enable),
      .inc_i(aw_hs && (snp_q.awid == BW_AXI_TID'(i))),
      .dec_i(b_hs  && (snp_q.bid  == BW_AXI_TID'(i))),
      .cnt_o(wcnt[i]), .cnt_nxt_o(wcnt_nxt[i]), .ovf_o(w_ovf[i]), .unexp_o(w_unexp[i]));
    axi_txn_id_cnt #(.W(BW_OUTSTANDING)) u_rcnt (
      .clk_i(clk), .rstnn_i(rstnn), .en_i(enable),
      .inc_i(ar_hs && (snp_q.arid == BW_AXI_TID'(i))),
      .dec_i(rl_hs && (snp_q.rid  == BW_AXI_TID'(i))),
      .cnt_o(rcnt[i]), .cnt_nxt_o(rcnt_nxt[i]), .ovf_o(r_ovf[i]), .unexp_o(r_unexp[i]));
  end

  logic [BW_TOTAL-1:0]       wr_sum, rd_sum;
  logic [BW_OUTSTANDING-1:0] wmax_nxt, rmax_nxt;

  always_comb begin
    wr_sum   = '0;
    rd_sum   = '0;
    wmax_nxt = '0;
    rmax_nxt = '0;
    for (int i = 0; i < NUM_ID; i++) begin
      wr_sum = wr_sum + BW_TOTAL'(wcnt[i]);
      rd_sum = rd_sum + BW_TOTAL'(rcnt[i]);
      if (wcnt_nxt[i] > wmax_nxt) wmax_nxt = wcnt_nxt[i];
      if (rcnt_nxt[i] > rmax_nxt) rmax_nxt = rcnt_nxt[i];
    end
  end

  // Two's-complement burst balance; negative when W data runs ahead of AW
  logic [PW-1:0] wpend_q, wpend_d;
  logic          wpend_pos;

  always_comb begin
    wpend_d = wpend_q;
    if (enable) begin
      if (aw_hs && !wl_hs)      wpend_d = wpend_q + PW'(1);
      else if (!aw_hs && wl_hs) wpend_d = wpend_q - PW'(1);
    end
  end
  assign wpend_pos = !wpend_q[PW-1] && (wpend_q != '0);

  logic [BW_TIMER-1:0] thr_q;
  logic [2:0]          wd_busy, wd_hs, wd_hit;
  assign wd_busy = {rd_sum != '0, wr_sum != '0, wpend_pos};
  assign wd_hs   = {r_hs, b_hs, w_hs};

  for (genvar t = 0; t < 3; t++) begin : g_wd
    axi_txn_wdog #(.W(BW_TIMER)) u_wd (
      .clk_i(clk), .rstnn_i(rstnn), .en_i(enable), .ld_i(cfg_timeout_we),
      .thr_i(thr_q), .busy_i(wd_busy[t]), .hs_i(wd_hs[t]), .hit_o(wd_hit[t]));
  end

  logic [2:0]                tmo_q;
  logic [3:0]                err_q, err_set;
  logic [BW_OUTSTANDING-1:0] wpk_q, rpk_q;
  logic                      irq_q;
  assign err_set = {|r_unexp, |w_unexp, |r_ovf, |w_ovf};

  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn) begin
      wpend_q <= '0;
      thr_q   <= BW_TIMER'(DEFAULT_TIMEOUT);
      tmo_q   <= '0;
      err_q   <= '0;
      wpk_q   <= '0;
      rpk_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      wpend_q <= wpend_d;
      if (cfg_timeout_we) thr_q <= cfg_timeout;
      tmo_q <= (clear ? 3'b000 : tmo_q) | wd_hit;
      err_q <= (clear ? 4'b0000 : err_q) | err_set;
      if (clear) begin
        wpk_q <= wmax_nxt;
        rpk_q <= rmax_nxt;
      end else if (enable) begin
        if (wmax_nxt > wpk_q) wpk_q <= wmax_nxt;
        if (rmax_nxt > rpk_q) rpk_q <= rmax_nxt;
      end
      irq_q <= |{tmo_q, err_q};
    end

  assign wr_total      = wr_sum;
  assign rd_total      = rd_sum;
  assign wr_peak       = wpk_q;
  assign rd_peak       = rpk_q;
  assign timeout_flags = tmo_q;
  assign error_flags   = err_q;
  assign irq           = irq_q;
endmodule

// File: tb/tb_axi_txn_tracking_monitor.sv
// Bench for axi_txn_tracking_monitor: random traffic against a transaction-level
// model, then directed watchdog, clear, enable and reset scenarios.
module tb_axi_txn_tracking_monitor;
  logic        clk = 1'b0, rstnn, enable, clear, cfg_timeout_we;
  logic [15:0] cfg_timeout;
  logic [3:0]  awid, bid, arid, rid;
  logic [7:0]  awlen;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [7:0]  wr_total, rd_total;
  logic [3:0]  wr_peak, rd_peak, error_flags;
  logic [2:0]  timeout_flags;
  logic        irq;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  axi_txn_tracking_monitor dut (
    .clk(clk), .rstnn(rstnn), .enable(enable), .clear(clear),
    .cfg_timeout_we(cfg_timeout_we), .cfg_timeout(cfg_timeout),
    .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bvalid(bvalid), .bready(bready),
    .arid(arid), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .wr_total(wr_total), .rd_total(rd_total), .wr_peak(wr_peak), .rd_peak(rd_peak),
    .timeout_flags(timeout_flags), .error_flags(error_flags), .irq(irq));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, want, want, $time);
    end
  endtask

  task automatic idle();
    {awvalid, awready, wvalid, wready, wlast, bvalid, bready} = '0;
    {arvalid, arready, rvalid, rready, rlast} = '0;
    {awid, bid, arid, rid} = '0;
    awlen = 8'd0;
    clear = 1'b0;
    cfg_timeout_we = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wr_total"}, wr_total, 0);
    chk({tag, ".rd_total"}, rd_total, 0);
    chk({tag, ".wr_peak"}, wr_peak, 0);
    chk({tag, ".rd_peak"}, rd_peak, 0);
    chk({tag, ".tmo"}, timeout_flags, 0);
    chk({tag, ".err"}, error_flags, 0);
    chk({tag, ".irq"}, irq, 0);
  endtask

  // Model state as seen two cycles after the inputs that produced it
  typedef struct {
    int wtot, rtot, wpk, rpk, wmax, rmax;
    logic [3:0] err, ev;
  } snap_t;

  snap_t hist[$];
  snap_t s, p, q;
  int    wc[16], rc[16];

  initial begin
    idle();
    enable = 1'b1;
    cfg_timeout = '0;
    rstnn = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstnn = 1'b1;
    @(negedge clk); cfg_timeout_we = 1'b1; cfg_timeout = 16'd0;
    @(negedge clk); cfg_timeout_we = 1'b0;

    // ---------------- random traffic vs. model (watchdogs disabled) ----------
    s = '{default: 0};
    repeat (3) hist.push_back(s);
    for (int i = 0; i < 16; i++) begin wc[i] = 0; rc[i] = 0; end

    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      p = hist[hist.size()-2];
      q = hist[hist.size()-3];
      chk("rnd.wr_total", wr_total, p.wtot);
      chk("rnd.rd_total", rd_total, p.rtot);
      chk("rnd.wr_peak", wr_peak, p.wpk);
      chk("rnd.rd_peak", rd_peak, p.rpk);
      chk("rnd.err", error_flags, p.err);
      chk("rnd.tmo", timeout_flags, 0);
      chk("rnd.irq", irq, |q.err);

      awvalid = $urandom_range(0, 9) < 4; awready = $urandom_range(0, 3) != 0;
      awid    = 4'($urandom_range(0, 3));
      awlen   = 8'($urandom_range(0, 255));
      wvalid  = $urandom_range(0, 1);     wready  = $urandom_range(0, 1);
      wlast   = $urandom_range(0, 1);
      bvalid  = $urandom_range(0, 9) < 4; bready  = $urandom_range(0, 3) != 0;
      bid     = 4'($urandom_range(0, 3));
      arvalid = $urandom_range(0, 9) < 4; arready = $urandom_range(0, 3) != 0;
      arid    = 4'($urandom_range(0, 3));
      rvalid  = $urandom_range(0, 9) < 6; rready  = $urandom_range(0, 3) != 0;
      rlast   = $urandom_range(0, 1);
      rid     = 4'($urandom_range(0, 3));
      clear   = $urandom_range(0, 19) == 0;

      // clear lands together with the previous cycle's events; those win
      if (clear) begin
        s = hist[hist.size()-1];
        s.err = s.ev; s.wpk = s.wmax; s.rpk = s.rmax;
        hist[hist.size()-1] = s;
      end

      s = hist[hist.size()-1];
      s.ev = '0;
      if (!(awvalid && awready && bvalid && bready && awid == bid)) begin
        if (awvalid && awready) begin
          if (wc[awid] == 15) s.ev[0] = 1'b1; else wc[awid]++;
        end
        if (bvalid && bready) begin
          if (wc[bid] == 0) s.ev[2] = 1'b1; else wc[bid]--;
        end
      end
      if (!(arvalid && arready && rvalid && rready && rlast && arid == rid)) begin
        if (arvalid && arready) begin
          if (rc[arid] == 15) s.ev[1] = 1'b1; else rc[arid]++;
        end
        if (rvalid && rready && rlast) begin
          if (rc[rid] == 0) s.ev[3] = 1'b1; else rc[rid]--;
        end
      end
      s.wtot = 0; s.rtot = 0; s.wmax = 0; s.rmax = 0;
      for (int i = 0; i < 16; i++) begin
        s.wtot += wc[i]; s.rtot += rc[i];
        if (wc[i] > s.wmax) s.wmax = wc[i];
        if (rc[i] > s.rmax) s.rmax = rc[i];
      end
      if (s.wmax > s.wpk) s.wpk = s.wmax;
      if (s.rmax > s.rpk) s.rpk = s.rmax;
      s.err = s.err | s.ev;
      hist.push_back(s);
    end
    @(negedge clk); idle();
    repeat (2) @(negedge clk);

    // async reset with traffic outstanding
    #2 rstnn = 1'b0;
    #1 chk_all_zero("async_rst1");
    @(negedge clk); rstnn = 1'b1;
    @(negedge clk); cfg_timeout_we = 1'b1; cfg_timeout = 16'd0;
    @(negedge clk); cfg_timeout_we = 1'b0;

    // ---------------- basic accounting and two-cycle latency ----------------
    awvalid = 1; awready = 1; awid = 4'd3;
    @(negedge clk); chk("d1.wr_total_n1", wr_total, 0);
    awvalid = 0; awready = 0; arvalid = 1; arready = 1; arid = 4'd3;
    @(negedge clk); chk("d1.wr_total_n2", wr_total, 1); chk("d1.rd_total_n2", rd_total, 0);
    @(negedge clk); chk("d1.rd_total_a", rd_total, 1);
    arvalid = 0; arready = 0; rvalid = 1; rready = 1; rid = 4'd3; rlast = 1;
    @(negedge clk); chk("d1.rd_total_b", rd_total, 2);
    rvalid = 0; rready = 0; rlast = 0;
    @(negedge clk); chk("d1.rd_total_c", rd_total, 1);
    chk("d1.wr_peak", wr_peak, 1); chk("d1.rd_peak", rd_peak, 2); chk("d1.err", error_flags, 0);

    // ---------------- write overflow on one ID, then clear ------------------
    awvalid = 1; awready = 1; awid = 4'd5;
    repeat (16) @(negedge clk);
    awvalid = 0; awready = 0;
    chk("d2.err_pre", error_flags, 0); chk("d2.wr_peak_pre", wr_peak, 15);
    @(negedge clk); chk("d2.err_ovf", error_flags, 4'b0001); chk("d2.irq_pre", irq, 0);
    chk("d2.wr_total", wr_total, 16);
    @(negedge clk); chk("d2.irq", irq, 1); clear = 1;
    @(negedge clk); clear = 0; chk("d2.err_clr", error_flags, 0); chk("d2.wr_peak_kept", wr_peak, 15);
    @(negedge clk); chk("d2.irq_clr", irq, 0);

    // ---------------- unexpected responses ----------------------------------
    bvalid = 1; bready = 1; bid = 4'd2;
    @(negedge clk); bvalid = 0; bready = 0;
    @(negedge clk); chk("d3.unexp_b", error_flags, 4'b0100); chk("d3.wr_total", wr_total, 16);
    clear = 1;
    @(negedge clk); clear = 0; chk("d3.err_clr", error_flags, 0);
    awvalid = 1; awready = 1; awid = 4'd2; bvalid = 1; bready = 1; bid = 4'd2;
    @(negedge clk); idle();
    @(negedge clk); chk("d3.same_id_err", error_flags, 0); chk("d3.same_id_tot", wr_total, 16);
    rvalid = 1; rready = 1; rlast = 1; rid = 4'd9;
    @(negedge clk); idle();
    @(negedge clk); chk("d3.unexp_r", error_flags, 4'b1000); chk("d3.rd_total", rd_total, 1);

    #2 rstnn = 1'b0;
    #1 chk_all_zero("async_rst2");
    @(negedge clk); rstnn = 1'b1;

    // ---------------- R watchdog at threshold 10 ----------------------------
    @(negedge clk); cfg_timeout_we = 1; cfg_timeout = 16'd10;
    @(negedge clk); cfg_timeout_we = 0; arvalid = 1; arready = 1; arid = 4'd3;
    @(negedge clk); idle();
    @(negedge clk); chk("d4.rd_total", rd_total, 1);
    repeat (9) @(negedge clk); chk("d4.tmo_pre", timeout_flags, 0);
    @(negedge clk); chk("d4.tmo_r", timeout_flags, 3'b100);
    @(negedge clk); chk("d4.irq", irq, 1);
    rvalid = 1; rready = 1; rlast = 1; rid = 4'd3;
    @(negedge clk); idle();
    @(negedge clk); chk("d4.rd_done", rd_total, 0); clear = 1;
    @(negedge clk); clear = 0; chk("d4.tmo_clr", timeout_flags, 0);

    arvalid = 1; arready = 1; arid = 4'd3;
    @(negedge clk); idle();
    repeat (8) @(negedge clk);
    rvalid = 1; rready = 1; rid = 4'd3; rlast = 0;
    @(negedge clk); idle();
    repeat (2) @(negedge clk); chk("d4b.tmo_kick", timeout_flags, 0);
    repeat (8) @(negedge clk); chk("d4b.tmo_pre", timeout_flags, 0);
    @(negedge clk); chk("d4b.tmo_r", timeout_flags, 3'b100);
    rvalid = 1; rready = 1; rlast = 1; rid = 4'd3;
    @(negedge clk); idle();
    @(negedge clk); chk("d4b.rd_done", rd_total, 0); clear = 1;
    @(negedge clk); clear = 0; chk("d4b.tmo_clr", timeout_flags, 0);

    // ---------------- W before AW, then W/B watchdogs -----------------------
    wvalid = 1; wready = 1; wlast = 1;
    @(negedge clk); idle();
    repeat (14) @(negedge clk); chk("d5.no_w_tmo", timeout_flags, 0);
    awvalid = 1; awready = 1; awid = 4'd1;
    @(negedge clk); idle();
    repeat (2) @(negedge clk); chk("d5.wr_total", wr_total, 1);
    bvalid = 1; bready = 1; bid = 4'd1;
    @(negedge clk); idle();
    repeat (15) @(negedge clk);
    chk("d5.tmo", timeout_flags, 0); chk("d5.wr_total_end", wr_total, 0); chk("d5.err", error_flags, 0);
    awvalid = 1; awready = 1; awid = 4'd0;
    @(negedge clk); idle();
    repeat (10) @(negedge clk); chk("d5.wb_tmo_pre", timeout_flags, 0);
    @(negedge clk); chk("d5.wb_tmo", timeout_flags, 3'b011);

    rstnn = 1'b0;
    @(negedge clk); rstnn = 1'b1;

    // ---------------- enable freeze at threshold 5 --------------------------
    @(negedge clk); cfg_timeout_we = 1; cfg_timeout = 16'd5;
    @(negedge clk); cfg_timeout_we = 0; arvalid = 1; arready = 1; arid = 4'd4;
    @(negedge clk); idle();
    @(negedge clk); chk("d6.rd_total", rd_total, 1); enable = 0;
    repeat (3) @(negedge clk); arvalid = 1; arready = 1; arid = 4'd4;
    @(negedge clk); idle();
    repeat (15) @(negedge clk);
    chk("d6.frozen_tot", rd_total, 1); chk("d6.frozen_tmo", timeout_flags, 0);
    @(negedge clk); enable = 1; chk("d6.tmo_en", timeout_flags, 0);
    repeat (3) @(negedge clk); chk("d6.rd_total_after", rd_total, 1);
    @(negedge clk); chk("d6.tmo_pre", timeout_flags, 0);
    @(negedge clk); chk("d6.tmo_r", timeout_flags, 3'b100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
